// File: rtl/rv32i_multicycle_ctrl_if.sv
// Handshake and control bundle between the RV32I multicycle controller (master)
// and the datapath / memory side (slave).
interface rv32i_multicycle_ctrl_if;
  logic [31:0] instr;
  logic        imem_ready;
  logic        dmem_ready;
  logic        br_taken;
  logic        IRWr;
  logic        PCWr;
  logic        PCSrc;
  logic        ALUASrc;
  logic        ALUBSrc;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUOp;
  logic        DMRd;
  logic        DMWr;
  logic [2:0]  DMCtrl;
  logic        RUWr;
  logic [1:0]  RUDataWrSrc;
  logic        trap;

  modport master (
    input  instr, imem_ready, dmem_ready, br_taken,
    output IRWr, PCWr, PCSrc, ALUASrc, ALUBSrc, ImmSrc, ALUOp,
           DMRd, DMWr, DMCtrl, RUWr, RUDataWrSrc, trap
  );

  modport slave (
    output instr, imem_ready, dmem_ready, br_taken,
    input  IRWr, PCWr, PCSrc, ALUASrc, ALUBSrc, ImmSrc, ALUOp,
           DMRd, DMWr, DMCtrl, RUWr, RUDataWrSrc, trap
  );
endinterface

// File: rtl/rv32i_multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a sticky
// illegal-opcode trap. Outputs are registered from the next state.
module rv32i_multicycle_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rv32i_multicycle_ctrl_if.master  bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_J = 3'b110;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b1001;

  state_t     state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       is_r, is_i, is_ld, is_st, is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic       is_jump, is_legal;
  logic [3:0] alu_op;
  logic [2:0] imm_sel;

  logic       fetch_q, pcwr_q, pcsrc_q, brsel_q, stpc_q;
  logic       alua_q, alub_q;
  logic [2:0] imm_q;
  logic [3:0] aluop_q;
  logic       dmrd_q, dmwr_q;
  logic [2:0] dmctrl_q;
  logic       ruwr_q;
  logic [1:0] wbsrc_q;
  logic       trap_q;

  assign opcode   = bus.instr[6:0];
  assign funct3   = bus.instr[14:12];
  assign funct7_5 = bus.instr[30];

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_br    = (opcode == OP_BR);
  assign is_jump  = is_jal | is_jalr;
  assign is_legal = is_r | is_i | is_ld | is_st | is_lui | is_auipc | is_jump | is_br;

  // Immediate shifts take funct7[5] (SRAI); every other I-ALU op ignores the upper bits.
  always_comb begin
    alu_op = ALU_ADD;
    if (is_r)
      alu_op = {funct7_5, funct3};
    else if (is_i)
      alu_op = {(funct3 == 3'b101) & funct7_5, funct3};
    else if (is_lui)
      alu_op = ALU_PASSB;
  end

  always_comb begin
    imm_sel = IMM_I;
    if (is_st)                 imm_sel = IMM_S;
    else if (is_lui | is_auipc) imm_sel = IMM_U;
    else if (is_br)            imm_sel = IMM_B;
    else if (is_jal)           imm_sel = IMM_J;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.imem_ready) state_d = S_DECODE;
      S_DECODE: state_d = is_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_ld | is_st) state_d = S_MEM;
        else if (is_br)    state_d = S_FETCH;
        else               state_d = S_WB;
      end
      S_MEM:    if (bus.dmem_ready) state_d = is_ld ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are decoded from the state being entered, so they are valid for the whole state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= state_t'(RESET_STATE);
      fetch_q  <= (RESET_STATE == 3'd0);
      pcwr_q   <= 1'b0;
      pcsrc_q  <= 1'b0;
      brsel_q  <= 1'b0;
      stpc_q   <= 1'b0;
      alua_q   <= 1'b0;
      alub_q   <= 1'b0;
      imm_q    <= 3'b000;
      aluop_q  <= 4'b0000;
      dmrd_q   <= 1'b0;
      dmwr_q   <= 1'b0;
      dmctrl_q <= 3'b000;
      ruwr_q   <= 1'b0;
      wbsrc_q  <= 2'b00;
      trap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fetch_q  <= 1'b0;
      pcwr_q   <= 1'b0;
      pcsrc_q  <= 1'b0;
      brsel_q  <= 1'b0;
      stpc_q   <= 1'b0;
      alua_q   <= 1'b0;
      alub_q   <= 1'b0;
      imm_q    <= 3'b000;
      aluop_q  <= 4'b0000;
      dmrd_q   <= 1'b0;
      dmwr_q   <= 1'b0;
      dmctrl_q <= 3'b000;
      ruwr_q   <= 1'b0;
      wbsrc_q  <= 2'b00;
      trap_q   <= 1'b0;
      case (state_d)
        S_FETCH: fetch_q <= 1'b1;
        S_EXEC: begin
          aluop_q <= alu_op;
          alua_q  <= is_auipc | is_jal | is_br;
          alub_q  <= ~is_r;
          imm_q   <= imm_sel;
          pcwr_q  <= is_jump | is_br;
          pcsrc_q <= is_jump;
          brsel_q <= is_br;
        end
        S_MEM: begin
          dmrd_q   <= is_ld;
          dmwr_q   <= is_st;
          dmctrl_q <= funct3;
          stpc_q   <= is_st;
        end
        S_WB: begin
          ruwr_q  <= 1'b1;
          pcwr_q  <= ~is_jump;
          wbsrc_q <= is_ld ? 2'b01 : (is_jump ? 2'b10 : 2'b00);
        end
        S_TRAP:  trap_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // fetch_q leaves reset set, so rst_n also gates IRWr while reset is held.
  assign bus.IRWr        = fetch_q & bus.imem_ready & rst_n;
  assign bus.PCWr        = pcwr_q | (stpc_q & bus.dmem_ready);
  assign bus.PCSrc       = pcsrc_q | (brsel_q & bus.br_taken);
  assign bus.ALUASrc     = alua_q;
  assign bus.ALUBSrc     = alub_q;
  assign bus.ImmSrc      = imm_q;
  assign bus.ALUOp       = aluop_q;
  assign bus.DMRd        = dmrd_q;
  assign bus.DMWr        = dmwr_q;
  assign bus.DMCtrl      = dmctrl_q;
  assign bus.RUWr        = ruwr_q;
  assign bus.RUDataWrSrc = wbsrc_q;
  assign bus.trap        = trap_q;
endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Bench for rv32i_multicycle_ctrl: per-instruction expected cycle traces built from
// the ISA-level rules, replayed cycle by cycle, plus literal spot checks.
module tb_rv32i_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv32i_multicycle_ctrl_if bus();
  rv32i_multicycle_ctrl #(.RESET_STATE(3'd0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic       irwr;
    logic       pcwr;
    logic       pcsrc;
    logic       alua;
    logic       alub;
    logic [2:0] imm;
    logic [3:0] aluop;
    logic       dmrd;
    logic       dmwr;
    logic [2:0] dmctrl;
    logic       ruwr;
    logic [1:0] wbsrc;
    logic       trap;
  } outs_t;

  typedef struct {
    string       nm;
    logic [31:0] instr;
    logic        imem;
    logic        dmem;
    logic        br;
    outs_t       exp;
  } rec_t;

  rec_t  q[$];
  outs_t obs [0:511];
  outs_t dut_o;
  int    n_chk = 0;
  int    n_fail = 0;
  int    run_idx = 0;

  assign dut_o = {bus.IRWr, bus.PCWr, bus.PCSrc, bus.ALUASrc, bus.ALUBSrc, bus.ImmSrc,
                  bus.ALUOp, bus.DMRd, bus.DMWr, bus.DMCtrl, bus.RUWr, bus.RUDataWrSrc, bus.trap};

  // Expected per-cycle trace of one instruction. fw/mw = wait cycles before imem/dmem ready,
  // nz = drive the ready/branch inputs high whenever they must be ignored.
  task automatic add_trace(input string nm, input logic [31:0] ins, input int fw, input int mw,
                           input logic br, input logic nz, input logic abort_mem, input int trap_cyc);
    rec_t       r;
    logic [6:0] op;
    logic [2:0] f3;
    bit alu_r, alu_i, ld, st, lui, auipc, jal, jmp, brn, legal;
    op    = ins[6:0];
    f3    = ins[14:12];
    alu_r = (op == 7'h33);
    alu_i = (op == 7'h13);
    ld    = (op == 7'h03);
    st    = (op == 7'h23);
    lui   = (op == 7'h37);
    auipc = (op == 7'h17);
    jal   = (op == 7'h6F);
    jmp   = jal || (op == 7'h67);
    brn   = (op == 7'h63);
    legal = alu_r || alu_i || ld || st || lui || auipc || jmp || brn;
    r.nm  = nm;
    for (int i = 0; i <= fw; i++) begin
      r.instr = 32'hFFFF_FFFF;
      r.imem = (i == fw);
      r.dmem = nz;
      r.br = nz;
      r.exp = '0;
      r.exp.irwr = (i == fw);
      q.push_back(r);
    end
    r.instr = ins;
    r.imem = nz;
    r.exp = '0;
    q.push_back(r);
    if (!legal) begin
      for (int i = 0; i < trap_cyc; i++) begin
        r.exp = '0;
        r.exp.trap = 1'b1;
        q.push_back(r);
      end
      return;
    end
    r.exp = '0;
    r.br = brn ? br : nz;
    if (alu_r)      r.exp.aluop = {ins[30], f3};
    else if (alu_i) r.exp.aluop = {(f3 == 3'b101) && ins[30], f3};
    else if (lui)   r.exp.aluop = 4'b1001;
    r.exp.alub  = !alu_r;
    r.exp.alua  = auipc || jal || brn;
    r.exp.imm   = st ? 3'b001 : (lui || auipc) ? 3'b010 : brn ? 3'b101 : jal ? 3'b110 : 3'b000;
    r.exp.pcwr  = jmp || brn;
    r.exp.pcsrc = jmp || (brn && br);
    q.push_back(r);
    r.br = nz;
    if (brn) return;
    if (ld || st) begin
      for (int i = 0; i <= mw; i++) begin
        if (abort_mem && (i == mw)) return;
        r.exp = '0;
        r.dmem = (i == mw);
        r.exp.dmrd = ld;
        r.exp.dmwr = st;
        r.exp.dmctrl = f3;
        r.exp.pcwr = st && (i == mw);
        q.push_back(r);
      end
      if (st) return;
    end
    r.dmem = nz;
    r.exp = '0;
    r.exp.ruwr = 1'b1;
    r.exp.pcwr = !jmp;
    r.exp.wbsrc = ld ? 2'b01 : (jmp ? 2'b10 : 2'b00);
    q.push_back(r);
  endtask

  task automatic run_pending();
    while (run_idx < q.size()) begin
      @(posedge clk);
      #1;
      bus.instr      = q[run_idx].instr;
      bus.imem_ready = q[run_idx].imem;
      bus.dmem_ready = q[run_idx].dmem;
      bus.br_taken   = q[run_idx].br;
      @(negedge clk);
      obs[run_idx] = dut_o;
      n_chk++;
      if (dut_o !== q[run_idx].exp) begin
        n_fail++;
        $display("FAIL %s rec%0d: outputs got %h, required %h", q[run_idx].nm, run_idx, dut_o, q[run_idx].exp);
      end
      run_idx++;
    end
  endtask

  task automatic check_zero(input string nm);
    n_chk++;
    if (dut_o !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs got %h, required %h", nm, dut_o, outs_t'('0));
    end
  endtask

  // Asynchronous reset with every ready/branch input high; outputs must all read zero.
  task automatic reset_check(input string nm);
    #1 rst_n = 1'b0;
    #1;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    bus.br_taken   = 1'b1;
    #1 check_zero({nm, "_async"});
    repeat (2) @(posedge clk);
    #1 check_zero({nm, "_held"});
    rst_n = 1'b1;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.br_taken   = 1'b0;
  endtask

  task automatic pin(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, got, want);
    end
  endtask

  function automatic int count_en(input int a, input int n, input int which);
    int c = 0;
    for (int i = a; i < a + n; i++) begin
      if (which == 0 && obs[i].dmrd) c++;
      if (which == 1 && obs[i].ruwr) c++;
    end
    return c;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int b_add, b_srai, b_srli, b_sub, b_addi, b_lui, b_auipc, b_jal, b_jalr;
    int b_lw, b_lbu, b_sw, b_sww, b_beqt, b_beqn, b_end, b_add2, b_ill;
    rst_n = 1'b1;
    bus.instr = 32'h0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.br_taken = 1'b0;
    reset_check("reset_init");

    b_add   = q.size(); add_trace("add",   32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    b_srai  = q.size(); add_trace("srai",  32'h4032D293, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    b_srli  = q.size(); add_trace("srli",  32'h0032D293, 1, 0, 1'b0, 1'b0, 1'b0, 0);
    b_sub   = q.size(); add_trace("sub",   32'h402081B3, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    b_addi  = q.size(); add_trace("addi",  32'h40028293, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    b_lui   = q.size(); add_trace("lui",   32'h123452B7, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    b_auipc = q.size(); add_trace("auipc", 32'h00001297, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    b_jal   = q.size(); add_trace("jal",   32'h010000EF, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    b_jalr  = q.size(); add_trace("jalr",  32'h00008067, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    b_lw    = q.size(); add_trace("lw",    32'h0000A303, 2, 3, 1'b0, 1'b1, 1'b0, 0);
    b_lbu   = q.size(); add_trace("lbu",   32'h0000C303, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    b_sw    = q.size(); add_trace("sw",    32'h0060A223, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    b_sww   = q.size(); add_trace("sw_wt", 32'h0060A223, 1, 2, 1'b0, 1'b1, 1'b0, 0);
    b_beqt  = q.size(); add_trace("beq_t", 32'h00208463, 0, 0, 1'b1, 1'b0, 1'b0, 0);
    b_beqn  = q.size(); add_trace("beq_n", 32'h00208463, 0, 0, 1'b0, 1'b1, 1'b0, 0);
    b_end   = q.size();
    run_pending();

    add_trace("sw_abort", 32'h0060A223, 0, 3, 1'b0, 1'b0, 1'b1, 0);
    run_pending();
    reset_check("reset_mem");

    b_add2 = q.size(); add_trace("add_rst", 32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    b_ill  = q.size(); add_trace("illegal", 32'hFFFFFFFF, 0, 0, 1'b0, 1'b1, 1'b0, 4);
    run_pending();
    reset_check("reset_trap");
    add_trace("add_trap", 32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    run_pending();

    pin("lat_add",      b_srai - b_add, 4);
    pin("add_exec_op",  int'(obs[b_add + 2].aluop), 0);
    pin("add_wb_ruwr",  int'(obs[b_add + 3].ruwr), 1);
    pin("add_refetch",  int'(obs[b_add + 4].irwr), 1);
    pin("srai_op",      int'(obs[b_srai + 2].aluop), 13);
    pin("srai_bsrc",    int'(obs[b_srai + 2].alub), 1);
    pin("srai_imm",     int'(obs[b_srai + 2].imm), 0);
    pin("srli_op",      int'(obs[b_srli + 3].aluop), 5);
    pin("sub_op",       int'(obs[b_sub + 2].aluop), 8);
    pin("addi_op",      int'(obs[b_addi + 2].aluop), 0);
    pin("lui_op",       int'(obs[b_lui + 2].aluop), 9);
    pin("jal_pcsrc",    int'(obs[b_jal + 2].pcsrc), 1);
    pin("jal_wbsrc",    int'(obs[b_jal + 3].wbsrc), 2);
    pin("jal_wb_pcwr",  int'(obs[b_jal + 3].pcwr), 0);
    pin("lw_dmrd_cyc",  count_en(b_lw, b_lbu - b_lw, 0), 4);
    pin("lw_ruwr_cyc",  count_en(b_lw, b_lbu - b_lw, 1), 1);
    pin("lw_wbsrc",     int'(obs[b_lw + 9].wbsrc), 1);
    pin("lat_load",     b_sw - b_lbu, 5);
    pin("lbu_dmctrl",   int'(obs[b_lbu + 3].dmctrl), 4);
    pin("lat_store",    b_sww - b_sw, 4);
    pin("sw_pcwr",      int'(obs[b_sw + 3].pcwr), 1);
    pin("lat_branch",   b_beqn - b_beqt, 3);
    pin("beq_t_pcwr",   int'(obs[b_beqt + 2].pcwr), 1);
    pin("beq_t_pcsrc",  int'(obs[b_beqt + 2].pcsrc), 1);
    pin("beq_n_pcsrc",  int'(obs[b_beqn + 2].pcsrc), 0);
    pin("beq_ruwr",     count_en(b_beqt, b_end - b_beqt, 1), 0);
    pin("rst_no_pcwr",  int'(obs[b_add2].pcwr), 0);
    pin("ill_trap",     int'(obs[b_ill + 2].trap), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
